spram_data_ctrl: RTL and testbench

//  Data-memory front end between the processor load/store unit and the 16K x 32 cascaded SPRAM.

---
 rtl/spram_pkg.sv | 17 +
 rtl/spram_load_align.sv | 25 ++
 rtl/spram_data_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spram_data_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared encodings for the SPRAM data-memory front end.
package spram_pkg;

    localparam int WORD_AW = 14;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

endpackage

// File: rtl/spram_load_align.sv
// Picks the addressed byte/half out of a 32-bit SPRAM word and sign/zero-extends it.
module spram_load_align
    import spram_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data[{off, 3'b000} +: 8];
        half_v = off[1] ? data[31:16] : data[15:0];
        case (size)
            SIZE_B:  rdata = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_H:  rdata = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: rdata = data;
        endcase
    end

endmodule

// File: rtl/spram_data_ctrl.sv
// Load/store front end for the 16K x 32 SPRAM: lane masks, load alignment and idle sleep control.
module spram_data_ctrl
    import spram_pkg::*;
#(
    parameter int IDLE_SLEEP  = 256,
    parameter int WAKE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [15:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [31:0]        mem_data_in,
    output logic [7:0]         mem_mask_wren,
    output logic               mem_wren,
    output logic               mem_chip_sel,
    output logic               mem_standby,
    output logic               mem_sleep,
    output logic               mem_poweroff,
    input  logic [31:0]        mem_data_out
);

    localparam int IW_RAW = $clog2(IDLE_SLEEP + 1);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;
    localparam int WW     = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SLEEP - 1);
    localparam logic [IW-1:0] IDLE_MAX  = '1;
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [WW-1:0] wake_q, wake_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          ld_q, ld_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;

    logic          accept;
    logic          req_err;
    logic [7:0]    mask_raw;
    logic [31:0]   aligned;

    assign req_ready = (state_q == ST_ACTIVE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        case (req_size)
            SIZE_B:  req_err = 1'b0;
            SIZE_H:  req_err = req_addr[0];
            SIZE_W:  req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Misaligned and reserved-size requests are swallowed without touching the SPRAM.
    assign mem_chip_sel  = accept & ~req_err;
    assign mem_wren      = mem_chip_sel & req_we;
    assign mem_addr      = req_addr[15:2];
    assign mem_mask_wren = mem_wren ? mask_raw : 8'h00;
    assign mem_standby   = 1'b0;
    assign mem_poweroff  = 1'b1;
    assign mem_sleep     = (state_q == ST_SLEEP);

    always_comb begin
        mask_raw    = 8'h00;
        mem_data_in = req_wdata;
        case (req_size)
            SIZE_B: begin
                mask_raw[{req_addr[1:0], 1'b0} +: 2] = 2'b11;
                mem_data_in = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                mask_raw    = req_addr[1] ? 8'hF0 : 8'h0F;
                mem_data_in = {2{req_wdata[15:0]}};
            end
            SIZE_W:  mask_raw = 8'hFF;
            default: mask_raw = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            ST_ACTIVE: begin
                if (accept) begin
                    idle_d = '0;
                end else begin
                    if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
                    if ((IDLE_SLEEP != 0) && (idle_q == IDLE_LAST)) begin
                        state_d = ST_SLEEP;
                        idle_d  = '0;
                    end
                end
            end
            ST_SLEEP: begin
                if (req_valid) begin
                    state_d = ST_WAKE;
                    wake_d  = '0;
                end
            end
            ST_WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept & req_err;
        ld_d        = accept & ~req_err & ~req_we;
        off_d       = accept ? req_addr[1:0] : off_q;
        size_d      = accept ? req_size      : size_q;
        uns_d       = accept ? req_unsigned  : uns_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACTIVE;
            idle_q      <= '0;
            wake_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_q        <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= SIZE_B;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            wake_q      <= wake_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_q        <= ld_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    spram_load_align u_align (
        .data        (mem_data_out),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (aligned)
    );

    // Stores and errors report zero data; only a completed load exposes the SPRAM word.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = ld_q ? aligned : 32'h0;

endmodule

// File: tb/tb_spram_data_ctrl.sv
// Directed bench for spram_data_ctrl with a behavioural SPRAM model behind it.
module tb_spram_data_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic [7:0]  mem_mask_wren;
    logic        mem_wren, mem_chip_sel, mem_standby, mem_sleep, mem_poweroff;

    int errors = 0;
    int checks = 0;

    logic        c_cs, c_wren;
    logic [7:0]  c_mask;
    logic [13:0] c_addr;
    logic [31:0] c_din;
    logic        r_valid, r_err;
    logic [31:0] r_rdata;

    logic [31:0] sram [0:16383];

    always #5 clk = ~clk;

    spram_data_ctrl #(.IDLE_SLEEP(8), .WAKE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_mask_wren(mem_mask_wren),
        .mem_wren(mem_wren), .mem_chip_sel(mem_chip_sel), .mem_standby(mem_standby),
        .mem_sleep(mem_sleep), .mem_poweroff(mem_poweroff), .mem_data_out(mem_data_out)
    );

    always @(posedge clk) begin
        if (mem_chip_sel) begin
            if (mem_wren) begin
                for (int n = 0; n < 8; n++)
                    if (mem_mask_wren[n]) sram[mem_addr][4*n +: 4] <= mem_data_in[4*n +: 4];
            end else begin
                mem_data_out <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one request, waits (bounded) for ready, captures the T and T+1 views.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata);
        int n;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        c_cs = mem_chip_sel; c_wren = mem_wren; c_mask = mem_mask_wren;
        c_addr = mem_addr; c_din = mem_data_in;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_valid = rsp_valid; r_err = rsp_err; r_rdata = rsp_rdata;
        $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> cs=%0b wren=%0b mask=%h rsp_valid=%0b err=%0b rdata=%h",
                 we, size, uns, addr, wdata, c_cs, c_wren, c_mask, r_valid, r_err, r_rdata);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_sleep",     32'(mem_sleep), 32'd0);
        check("rst_ready",     32'(req_ready), 32'd1);
        check("standby",       32'(mem_standby), 32'd0);
        check("poweroff",      32'(mem_poweroff), 32'd1);
        rst = 1'b0;

        // Word store / load
        do_req(1'b1, 2'b10, 1'b0, 16'h0100, 32'hDEADBEEF);
        check("sw_mask", 32'(c_mask), 32'h0000_00FF);
        check("sw_addr", 32'(c_addr), 32'h0000_0040);
        check("sw_wren", 32'(c_wren), 32'd1);
        check("sw_rsp_valid", 32'(r_valid), 32'd1);
        check("sw_rsp_rdata", r_rdata, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0);
        check("lw_cs", 32'(c_cs), 32'd1);
        check("lw_rdata", r_rdata, 32'hDEADBEEF);
        check("lw_valid", 32'(r_valid), 32'd1);

        // Byte store and signed/unsigned byte and half loads
        do_req(1'b1, 2'b00, 1'b0, 16'h0103, 32'h0000_0080);
        check("sb_mask", 32'(c_mask), 32'h0000_00C0);
        check("sb_din",  c_din, 32'h80808080);
        do_req(1'b0, 2'b00, 1'b0, 16'h0103, 32'h0);
        check("lb_signed", r_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 16'h0103, 32'h0);
        check("lb_unsigned", r_rdata, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 16'h0102, 32'h0);
        check("lh_signed_hi", r_rdata, 32'hFFFF80AD);
        do_req(1'b0, 2'b01, 1'b1, 16'h0100, 32'h0);
        check("lh_unsigned_lo", r_rdata, 32'h0000BEEF);
        do_req(1'b1, 2'b01, 1'b0, 16'h0102, 32'h0000_1234);
        check("sh_mask", 32'(c_mask), 32'h0000_00F0);
        check("sh_din",  c_din, 32'h12341234);
        do_req(1'b1, 2'b00, 1'b0, 16'h0101, 32'h0000_00AB);
        check("sb1_mask", 32'(c_mask), 32'h0000_000C);

        // Misaligned and reserved-size requests
        do_req(1'b0, 2'b01, 1'b0, 16'h0101, 32'h0);
        check("mis_h_cs",  32'(c_cs), 32'd0);
        check("mis_h_err", 32'(r_err), 32'd1);
        check("mis_h_rd",  r_rdata, 32'h0);
        check("mis_h_vld", 32'(r_valid), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 16'h0100, 32'h0);
        check("rsv_cs",  32'(c_cs), 32'd0);
        check("rsv_err", 32'(r_err), 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 16'h0102, 32'hFFFFFFFF);
        check("mis_w_wren", 32'(c_wren), 32'd0);
        check("mis_w_err",  32'(r_err), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0);
        check("lw_after_err", r_rdata, 32'h1234ABEF);
        check("lw_after_err_e", 32'(r_err), 32'd0);

        // Idle timeout, wake-up latency, then accept
        repeat (7) @(posedge clk);
        #1;
        check("idle7_sleep", 32'(mem_sleep), 32'd0);
        @(posedge clk); #1;
        check("idle8_sleep", 32'(mem_sleep), 32'd1);
        check("sleep_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0100;
        #1;
        check("sleep_cs", 32'(mem_chip_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("wake_ready_low", 32'(req_ready), 32'd0);
            check("wake_sleep_low", 32'(mem_sleep), 32'd0);
        end
        @(posedge clk); #1;
        check("wake_ready_high", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0);
        check("wake_load", r_rdata, 32'h1234ABEF);
        $display("sleep/wake sequence done");

        // Reset right after a load accept
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0100;
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(rsp_valid), 32'd0);
        check("rst_async_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        $display("reset-after-accept done");

        // Back-to-back store then load
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 16'h0200;
        req_wdata = 32'h12345678;
        #1;
        check("b2b_st_cs", 32'(mem_chip_sel), 32'd1);
        @(posedge clk); #1;
        req_we = 1'b0;
        check("b2b_st_valid", 32'(rsp_valid), 32'd1);
        check("b2b_ld_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_ld_valid", 32'(rsp_valid), 32'd1);
        check("b2b_ld_rdata", rsp_rdata, 32'h12345678);
        $display("back-to-back store/load rdata=%h", rsp_rdata);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
